// File: rtl/dual_boot_pkg.sv
// rtl/dual_boot_pkg.sv - register map, bit positions and FSM states for the dual-boot trigger
package dual_boot_pkg;

    localparam logic [2:0] DB_ADDR_TRIG   = 3'd0;
    localparam logic [2:0] DB_ADDR_SEL    = 3'd1;
    localparam logic [2:0] DB_ADDR_STATUS = 3'd3;

    localparam int DB_TRIG_BIT        = 0;
    localparam int DB_SEL_OVR_BIT     = 0;
    localparam int DB_SEL_BIT         = 1;
    localparam int DB_STATUS_BUSY_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_BUSY,
        ST_WAIT_BUSY,
        ST_WR_SEL,
        ST_RD_BUSY2,
        ST_WAIT_BUSY2,
        ST_WR_TRIG,
        ST_DONE
    } db_state_e;

    function automatic logic [31:0] db_sel_word(input logic image_sel);
        logic [31:0] w;
        w                 = '0;
        w[DB_SEL_OVR_BIT] = 1'b1;
        w[DB_SEL_BIT]     = image_sel;
        return w;
    endfunction

    function automatic logic [31:0] db_trig_word();
        logic [31:0] w;
        w              = '0;
        w[DB_TRIG_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/dual_boot_trigger_if.sv
// rtl/dual_boot_trigger_if.sv - Avalon-MM master port toward the dual-boot IP register space
interface dual_boot_trigger_if;
    logic [2:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser and debouncer emitting a one-cycle press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_q <= level;
            press   <= level_q & ~level;
            // Any cycle where the synced key agrees with the level restarts the count.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/dual_boot_trigger.sv
// rtl/dual_boot_trigger.sv - key-driven reconfiguration sequencer; image override under DUAL_BOOT_SEL_OVERRIDE_EN
module dual_boot_trigger
    import dual_boot_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter logic IMAGE_SEL       = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_n,
    dual_boot_trigger_if.master  avm,
    output logic                 busy,
    output logic                 led_n
);
    logic      press;
    db_state_e state;
    db_state_e next;
    logic      ip_busy;
    logic      rd_d;
    logic      wr_d;
    logic [2:0]  addr_d;
    logic [31:0] wdata_d;
    logic      unused_readdata;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .press   (press)
    );

    assign ip_busy         = avm.avm_readdata[DB_STATUS_BUSY_BIT];
    assign unused_readdata = ^avm.avm_readdata[31:1];

`ifndef DUAL_BOOT_SEL_OVERRIDE_EN
    logic unused_image_sel;
    assign unused_image_sel = IMAGE_SEL;
`endif

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:      if (press) next = ST_RD_BUSY;
            ST_RD_BUSY:   next = ST_WAIT_BUSY;
`ifdef DUAL_BOOT_SEL_OVERRIDE_EN
            ST_WAIT_BUSY:  next = ip_busy ? ST_RD_BUSY : ST_WR_SEL;
            ST_WR_SEL:     next = ST_RD_BUSY2;
            ST_RD_BUSY2:   next = ST_WAIT_BUSY2;
            ST_WAIT_BUSY2: next = ip_busy ? ST_RD_BUSY2 : ST_WR_TRIG;
`else
            ST_WAIT_BUSY:  next = ip_busy ? ST_RD_BUSY : ST_WR_TRIG;
`endif
            ST_WR_TRIG:   next = ST_DONE;
            ST_DONE:      next = ST_DONE;
            default:      next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop in the state's own cycle.
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (next)
            ST_RD_BUSY: begin
                rd_d   = 1'b1;
                addr_d = DB_ADDR_STATUS;
            end
`ifdef DUAL_BOOT_SEL_OVERRIDE_EN
            ST_RD_BUSY2: begin
                rd_d   = 1'b1;
                addr_d = DB_ADDR_STATUS;
            end
            ST_WR_SEL: begin
                wr_d    = 1'b1;
                addr_d  = DB_ADDR_SEL;
                wdata_d = db_sel_word(IMAGE_SEL);
            end
`endif
            ST_WR_TRIG: begin
                wr_d    = 1'b1;
                addr_d  = DB_ADDR_TRIG;
                wdata_d = db_trig_word();
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            avm.avm_address   <= '0;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_writedata <= '0;
            busy              <= 1'b0;
            led_n             <= 1'b1;
        end else begin
            state             <= next;
            avm.avm_address   <= addr_d;
            avm.avm_read      <= rd_d;
            avm.avm_write     <= wr_d;
            avm.avm_writedata <= wdata_d;
            busy              <= (next != ST_IDLE);
            led_n             <= (next == ST_IDLE);
        end
    end
endmodule

// File: tb/tb_dual_boot_trigger.sv
// tb/tb_dual_boot_trigger.sv - directed self-checking bench for dual_boot_trigger
module tb_dual_boot_trigger;
`ifdef DUAL_BOOT_SEL_OVERRIDE_EN
    localparam int TRIG_OFF = 5;
    localparam int TAIL_LEN = 3;
`else
    localparam int TRIG_OFF = 2;
    localparam int TAIL_LEN = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic key_n;
    logic busy;
    logic led_n;

    dual_boot_trigger_if avm ();

    dual_boot_trigger #(.DEBOUNCE_CYCLES(4), .IMAGE_SEL(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_n),
        .avm     (avm.master),
        .busy    (busy),
        .led_n   (led_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_txn = 0;
    int n_reads = 0;
    int viol = 0;
    int busy_rise = 0;
    logic busy_prev = 1'b0;
    int rd_base = 0;
    int busy_polls = 0;
    int base;
    int kf;
    int t_kind [64];
    int t_addr [64];
    logic [31:0] t_data [64];
    int t_cyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    // IP model: busy for the first busy_polls reads of a test, reserved bit1 always set.
    always @(posedge clk)
        avm.avm_readdata <= (avm.avm_read && (n_reads - rd_base) <= busy_polls) ? 32'h3 : 32'h2;

    always @(negedge clk) begin
        busy_prev <= busy;
        if (busy && !busy_prev) busy_rise <= cyc;
        if (avm.avm_read && avm.avm_write) viol <= viol + 1;
        if (!avm.avm_read && !avm.avm_write && (avm.avm_address != 3'd0 || avm.avm_writedata != 32'd0))
            viol <= viol + 1;
        if (avm.avm_read || avm.avm_write) begin
            if (n_txn < 64) begin
                t_kind[n_txn] <= avm.avm_write ? 1 : 0;
                t_addr[n_txn] <= int'(avm.avm_address);
                t_data[n_txn] <= avm.avm_writedata;
                t_cyc[n_txn]  <= cyc;
            end
            n_txn <= n_txn + 1;
            if (avm.avm_read) n_reads <= n_reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0; key_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic start_test(input int polls);
        @(negedge clk);
        rd_base    = n_reads;
        busy_polls = polls;
        base       = n_txn;
    endtask

    task automatic press_key();
        @(posedge clk); #1 key_n = 1'b0; kf = cyc;
        repeat (10) @(posedge clk);
        #1 key_n = 1'b1;
    endtask

    task automatic wait_txn(input int target);
        int t;
        t = 0;
        while (n_txn < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("wait_txn", 32'(n_txn >= target), 32'd1);
    endtask

    task automatic check_seq(input int polls);
        int i;
        int len;
        len = polls + 1 + TAIL_LEN;
        chk("seq_len", 32'(n_txn - base), 32'(len));
        for (i = 0; i < polls + 1; i++) begin
            chk("poll_kind", 32'(t_kind[base+i]), 32'd0);
            chk("poll_addr", 32'(t_addr[base+i]), 32'd3);
        end
`ifdef DUAL_BOOT_SEL_OVERRIDE_EN
        chk("sel_kind", 32'(t_kind[base+polls+1]), 32'd1);
        chk("sel_addr", 32'(t_addr[base+polls+1]), 32'd1);
        chk("sel_data", t_data[base+polls+1], 32'h3);
        chk("sel_time", 32'(t_cyc[base+polls+1] - busy_rise), 32'(2 * polls + 2));
        chk("poll2_kind", 32'(t_kind[base+polls+2]), 32'd0);
        chk("poll2_addr", 32'(t_addr[base+polls+2]), 32'd3);
`endif
        chk("trig_kind", 32'(t_kind[base+len-1]), 32'd1);
        chk("trig_addr", 32'(t_addr[base+len-1]), 32'd0);
        chk("trig_data", t_data[base+len-1], 32'h1);
        chk("trig_time", 32'(t_cyc[base+len-1] - busy_rise), 32'(2 * polls + TRIG_OFF));
        chk("first_rd_time", 32'(t_cyc[base] - busy_rise), 32'd0);
    endtask

    initial begin
        int t;
        int n_trig;
        reset_n = 1'b0;
        key_n   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_address", 32'(avm.avm_address), 32'd0);
        chk("rst_read", 32'(avm.avm_read), 32'd0);
        chk("rst_write", 32'(avm.avm_write), 32'd0);
        chk("rst_writedata", avm.avm_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led_n", 32'(led_n), 32'd1);
        @(posedge clk); #1 reset_n = 1'b1;

        start_test(0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 key_n = 1'b0;
            @(posedge clk);
            @(posedge clk); #1 key_n = 1'b1;
            @(posedge clk);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bounce_txn", 32'(n_txn - base), 32'd0);
        chk("bounce_busy", 32'(busy), 32'd0);

        start_test(0);
        press_key();
        wait_txn(base + 1 + TAIL_LEN);
        repeat (20) @(negedge clk);
        check_seq(0);
        chk("key_to_busy", 32'(busy_rise - kf), 32'd8);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_led_n", 32'(led_n), 32'd0);

        press_key();
        repeat (30) @(negedge clk);
        chk("done_press_ignored", 32'(n_txn - base), 32'(1 + TAIL_LEN));

        do_reset();
        chk("reset_clears_busy", 32'(busy), 32'd0);
        start_test(3);
        press_key();
        wait_txn(base + 4 + TAIL_LEN);
        repeat (20) @(negedge clk);
        check_seq(3);

        do_reset();
        start_test(10);
        press_key();
        press_key();
        wait_txn(base + 11 + TAIL_LEN);
        repeat (30) @(negedge clk);
        check_seq(10);
        n_trig = 0;
        for (int i = base; i < n_txn && i < 64; i++)
            if (t_kind[i] == 1 && t_addr[i] == 0) n_trig++;
        chk("single_trigger", 32'(n_trig), 32'd1);

        do_reset();
        start_test(0);
        @(posedge clk); #1 key_n = 1'b0;
        t = 0;
`ifdef DUAL_BOOT_SEL_OVERRIDE_EN
        while (!(avm.avm_write && avm.avm_address == 3'd1) && t < 50) begin
`else
        while (!avm.avm_read && t < 50) begin
`endif
            @(negedge clk);
            t++;
        end
        chk("midseq_marker_seen", 32'(t < 50), 32'd1);
        @(posedge clk); #1 reset_n = 1'b0; key_n = 1'b1;
        #1;
        chk("midrst_read", 32'(avm.avm_read), 32'd0);
        chk("midrst_write", 32'(avm.avm_write), 32'd0);
        chk("midrst_address", 32'(avm.avm_address), 32'd0);
        chk("midrst_writedata", avm.avm_writedata, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_led_n", 32'(led_n), 32'd1);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        start_test(0);
        press_key();
        wait_txn(base + 1 + TAIL_LEN);
        repeat (20) @(negedge clk);
        check_seq(0);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_boot_trigger.md
# dual_boot_trigger

Key-driven reconfiguration front end for the MAX10 dual-boot IP. Synchronises and debounces a push-button, then runs an Avalon-MM master sequence into the dual-boot IP's register port: poll busy, optionally select the target image, trigger reconfiguration. It sits directly upstream of the `dual_boot` instance in the board top and replaces its tied-off, request-less hookup. It also drives a status LED.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synced key must be stable before the debounced level changes (20 ms at 50 MHz).
- `IMAGE_SEL`, default 1'b1: configuration image to boot when the override is compiled in (0 = CFM0, 1 = CFM1/2).
- `clk`  in  1  system clock (`MAX10_CLK1_50`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw push-button, active-low, asynchronous to `clk`.
- `avm_address`  out  3  word address into the dual-boot IP.
- `avm_read`  out  1  read strobe, one cycle.
- `avm_write`  out  1  write strobe, one cycle.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  read data, valid exactly 1 cycle after `avm_read`.
- `busy`  out  1  high from the accepted press until reset.
- `led_n`  out  1  status LED, active-low; lit while `busy`.

## Operation
- Key path: 2-FF synchroniser, then debouncer. The debounced level resets to 1 and changes only after the synced input differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any bounce restarts the count. A 1→0 transition of the debounced level generates a one-cycle `press` pulse.
- Register map of the IP:
  - addr 0, write bit0=1: trigger reconfig.
  - addr 1, write bit0: config_sel_overwrite; bit1: config_sel.
  - addr 3, read bit0: busy; bit1: reserved, ignored.
- FSM states: IDLE, RD_BUSY, WAIT_BUSY, WR_SEL, RD_BUSY2, WAIT_BUSY2, WR_TRIG, DONE.
  - IDLE: on `press` go to RD_BUSY. All other key activity is ignored.
  - RD_BUSY: `avm_read`=1 and `avm_address`=3 for one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: sample `avm_readdata[0]`. If 1, go back to RD_BUSY; otherwise go to WR_SEL.
  - WR_SEL: `avm_write`=1, `avm_address`=1, `avm_writedata`={30'b0, IMAGE_SEL, 1'b1}, then go to RD_BUSY2.
  - RD_BUSY2 / WAIT_BUSY2: same polling as RD_BUSY / WAIT_BUSY. When not busy, go to WR_TRIG.
  - WR_TRIG: `avm_write`=1, `avm_address`=0, `avm_writedata`=32'h1, then go to DONE.
  - DONE: terminal. Outputs are idle and `busy` stays 1. The device reconfigures; only `reset_n` leaves this state.
- Polling is unbounded; no timeout.
- `avm_read` and `avm_write` are never high in the same cycle.
- When neither strobe is asserted, address and writedata are 0.
- A press arriving while not in IDLE is dropped and not queued.
- Reset asserted at any point, including mid-sequence or mid-debounce, immediately forces IDLE.

## Timing
- Reset values: `avm_address`=0, `avm_read`=0, `avm_write`=0, `avm_writedata`=0, `busy`=0, `led_n`=1. Synchroniser and debounced level reset to 1; the debounce counter resets to 0.
- All outputs are registered.
- Latency from a `key_n` fall to `press`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- `busy` rises in the cycle after `press`. The first `avm_read` is in the same cycle.
- With the IP never busy:
  - `press` to WR_SEL strobe: 3 cycles.
  - `press` to WR_TRIG strobe: 6 cycles.
- Each busy=1 poll adds 2 cycles.

## Configuration
- `DUAL_BOOT_SEL_OVERRIDE_EN` defined: the full sequence above runs, and `IMAGE_SEL` is written before the trigger.
- `DUAL_BOOT_SEL_OVERRIDE_EN` undefined:
  - WR_SEL, RD_BUSY2 and WAIT_BUSY2 are not compiled.
  - WAIT_BUSY with not-busy goes straight to WR_TRIG, so the image is chosen by the CONFIG_SEL pin.
  - `IMAGE_SEL` is unused.
  - `press` to WR_TRIG strobe: 3 cycles.

## Structure
- Shared package `dual_boot_pkg` holds:
  - register address constants: `DB_ADDR_TRIG`=0, `DB_ADDR_SEL`=1, `DB_ADDR_STATUS`=3.
  - bit-position constants.
  - the FSM state enum typedef.
- Sub-module `key_debounce`, parameter `DEBOUNCE_CYCLES`: contains the synchroniser, counter and debounced level, and outputs the one-cycle `press`.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4.
- Clean press: hold `key_n` low for 10 cycles, status read returns 0 → exactly one RD(3), one WR(1, 32'h3), one RD(3), one WR(0, 32'h1) in order, then `busy`=1 and `led_n`=0.
- Bounce: toggle `key_n` every 2 cycles for 20 cycles, then release high → no `press` and no Avalon traffic.
- IP busy: status returns bit0=1 for the first 3 polls → 3 extra RD(3) before WR(1); WR(0) is never issued while the last read showed busy.
- Second press while in WAIT_BUSY and while in DONE → ignored; exactly one WR(0) total.
- Reset mid-sequence: assert `reset_n`=0 in the cycle after WR_SEL → all outputs return to reset values at once; a new press restarts from RD(3).
- Macro undefined: clean press → RD(3), then WR(0, 32'h1) 3 cycles after `press`; no address-1 write.
